// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] CYCLO_OFF  = 4'h8;
    localparam logic [3:0] CYCHI_OFF  = 4'hC;

    localparam int FULL_BIT  = 0;
    localparam int EMPTY_BIT = 1;
    localparam int OVF_BIT   = 2;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_MMIO,
        SEL_NONE
    } sel_e;

    function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                                input logic ovf,
                                                input logic empty,
                                                input logic full);
        logic [31:0] w;
        w            = '0;
        w[15:8]      = cnt;
        w[OVF_BIT]   = ovf;
        w[EMPTY_BIT] = empty;
        w[FULL_BIT]  = full;
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// rtl/dmem_responder_tx_fifo.sv - console TX FIFO with valid/ready style head output
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands at the tail.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side RAM + MMIO responder
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter string       INIT_FILE  = "dmem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] dAddr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEn,
    output logic [31:0] dMemData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int          AW      = $clog2(RAM_WORDS);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(RAM_WORDS) * 33'd4;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   word_addr;
    logic [31:0]   ram_off;
    logic [AW-1:0] ram_idx;
    logic [3:0]    mmio_off;
    sel_e          sel;

    logic          mmio_wr;
    logic          txdata_wr;
    logic          status_wr;
    logic          cyclo_wr;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic [63:0]   cycles;
    logic          unused_bits;

    localparam string unused_init_file = INIT_FILE;

    assign word_addr   = {dAddr[31:2], 2'b00};
    assign ram_off     = word_addr - RAM_BASE;
    assign ram_idx     = ram_off[AW+1:2];
    assign mmio_off    = {dAddr[3:2], 2'b00};
    assign unused_bits = ^{dAddr[1:0], ram_off[31:AW+2], ram_off[1:0]};

    always_comb begin
        sel = SEL_NONE;
        if ({1'b0, word_addr} >= {1'b0, RAM_BASE} && {1'b0, word_addr} < RAM_END)
            sel = SEL_RAM;
        else if (dAddr[31:4] == MMIO_BASE[31:4])
            sel = SEL_MMIO;
    end

    // RAM has no reset: a store in the reset cycle still lands.
    always_ff @(posedge clk) begin
        if (MemWrite && sel == SEL_RAM) begin
            if (ByteEn[0]) ram[ram_idx][7:0]   <= WriteData[7:0];
            if (ByteEn[1]) ram[ram_idx][15:8]  <= WriteData[15:8];
            if (ByteEn[2]) ram[ram_idx][23:16] <= WriteData[23:16];
            if (ByteEn[3]) ram[ram_idx][31:24] <= WriteData[31:24];
        end
    end

    assign mmio_wr   = MemWrite && sel == SEL_MMIO;
    assign txdata_wr = mmio_wr && mmio_off == TXDATA_OFF && ByteEn[0];
    assign status_wr = mmio_wr && mmio_off == STATUS_OFF;
    assign cyclo_wr  = mmio_wr && mmio_off == CYCLO_OFF;
    assign pop       = tx_valid && tx_ready;
    assign push      = txdata_wr && (!full || pop);
    assign tx_valid  = !empty;

    tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_tx_fifo (
        .clk      (clk),
        .resetn   (reset),
        .push     (push),
        .push_data(WriteData[7:0]),
        .pop      (pop),
        .head_data(tx_data),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf     <= 1'b0;
            cycles  <= '0;
            bus_err <= 1'b0;
        end else begin
            // A dropped byte in the same cycle as a clear leaves ovf set.
            if (txdata_wr && full && !pop)
                ovf <= 1'b1;
            else if (status_wr && WriteData[OVF_BIT])
                ovf <= 1'b0;
            cycles <= cyclo_wr ? 64'd0 : cycles + 64'd1;
            if (MemWrite && sel == SEL_NONE)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        dMemData = '0;
        case (sel)
            SEL_RAM:  dMemData = ram[ram_idx];
            SEL_MMIO: begin
                case (mmio_off)
                    STATUS_OFF: dMemData = status_word(8'(fifo_count), ovf, empty, full);
                    CYCLO_OFF:  dMemData = cycles[31:0];
                    CYCHI_OFF:  dMemData = cycles[63:32];
                    default:    dMemData = '0;
                endcase
            end
            default:  dMemData = '0;
        endcase
    end

endmodule
